// File: rtl/path_replayer_if.sv
// Control/status bundle between a path source and the path_replayer motor sequencer.
interface path_replayer_if #(
  parameter int ENTRIES = 15
) ();
  logic                   start;
  logic                   abort;
  logic [7*ENTRIES-1:0]   path_data;
  logic [3:0]             entry_count;
  logic                   M1;
  logic                   M2;
  logic                   busy;
  logic                   done;
  logic                   aborted;

  modport master (
    output start, abort, path_data, entry_count,
    input  M1, M2, busy, done, aborted
  );

  modport slave (
    input  start, abort, path_data, entry_count,
    output M1, M2, busy, done, aborted
  );
endinterface

// File: rtl/path_replayer.sv
// Replays a recorded motor path oldest-slot-first, holding each {M2,M1} pair
// for (dur+1)*TICK cycles, with abort and clean completion pulses.
module path_replayer #(
  parameter int TICK    = 7644,
  parameter int ENTRIES = 15
) (
  input logic           clk,
  input logic           rst,
  path_replayer_if.slave bus
);
  localparam int TW = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t               state;
  logic [7*ENTRIES-1:0] snap;
  logic [3:0]           idx;
  logic [TW-1:0]        tick;
  logic [3:0]           unit;
  logic                 m1_q, m2_q, busy_q, done_q, aborted_q;

  logic [3:0] acc_cnt;
  logic [3:0] acc_idx;
  logic [3:0] nxt_idx;
  logic [6:0] first_slot;
  logic [6:0] cur_slot;
  logic [6:0] nxt_slot;

  function automatic logic [3:0] clamp_count(input logic [3:0] c);
    if (c > 4'(ENTRIES)) return 4'(ENTRIES);
    return c;
  endfunction

  function automatic logic [6:0] slot_of(input logic [7*ENTRIES-1:0] d, input logic [3:0] i);
    return d[7*int'(i) +: 7];
  endfunction

  // Index arithmetic is guarded so a select never reaches past the top slot.
  assign acc_cnt    = clamp_count(bus.entry_count);
  assign acc_idx    = (acc_cnt != 4'd0) ? acc_cnt - 4'd1 : 4'd0;
  assign nxt_idx    = (idx != 4'd0) ? idx - 4'd1 : 4'd0;
  assign first_slot = slot_of(bus.path_data, acc_idx);
  assign cur_slot   = slot_of(snap, idx);
  assign nxt_slot   = slot_of(snap, nxt_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      snap      <= '0;
      idx       <= '0;
      tick      <= '0;
      unit      <= '0;
      m1_q      <= 1'b0;
      m2_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            snap <= bus.path_data;
            tick <= '0;
            unit <= '0;
            idx  <= acc_idx;
            if (acc_cnt != 4'd0) begin
              {m2_q, m1_q} <= first_slot[1:0];
              busy_q       <= 1'b1;
              state        <= RUN;
            end else begin
              {m2_q, m1_q} <= 2'b00;
              done_q       <= 1'b1;
              state        <= FINISH;
            end
          end
        end
        RUN: begin
          // Abort is checked first so it wins over a coincident slot end.
          if (bus.abort) begin
            {m2_q, m1_q} <= 2'b00;
            busy_q       <= 1'b0;
            aborted_q    <= 1'b1;
            tick         <= '0;
            unit         <= '0;
            state        <= IDLE;
          end else if (tick == TICK_LAST) begin
            tick <= '0;
            if (unit == cur_slot[5:2]) begin
              unit <= '0;
              if (idx != 4'd0) begin
                idx          <= nxt_idx;
                {m2_q, m1_q} <= nxt_slot[1:0];
              end else begin
                {m2_q, m1_q} <= 2'b00;
                busy_q       <= 1'b0;
                done_q       <= 1'b1;
                state        <= FINISH;
              end
            end else begin
              unit <= unit + 4'd1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.M1      = m1_q;
  assign bus.M2      = m2_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.aborted = aborted_q;
endmodule

// File: tb/tb_path_replayer.sv
// Randomized scoreboard bench for path_replayer: a path-level model predicts
// output segments and completion pulses; a monitor extracts them from the pins.
module tb_path_replayer;
  localparam int TICK    = 4;
  localparam int ENTRIES = 15;
  localparam int PW      = 7 * ENTRIES;

  // kind: 0 = motor segment while busy, 1 = done pulse, 2 = aborted pulse
  typedef struct {
    int kind;
    int val;
    int cyc;
    int len;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  ev_t  expq[$];

  int   prev_busy = 0;
  int   cur_val = 0;
  int   seg_start = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  path_replayer_if #(.ENTRIES(ENTRIES)) bus ();

  path_replayer #(.TICK(TICK), .ENTRIES(ENTRIES)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic check_ev(input ev_t g);
    ev_t e;
    n_cmp++;
    if (expq.size() == 0) begin
      n_bad++;
      $display("FAIL event: got kind=%0d val=%0d cyc=%0d len=%0d, required none", g.kind, g.val, g.cyc, g.len);
    end else begin
      e = expq.pop_front();
      if (e.kind != g.kind || e.val != g.val || e.cyc != g.cyc || e.len != g.len) begin
        n_bad++;
        $display("FAIL event: got kind=%0d val=%0d cyc=%0d len=%0d, required kind=%0d val=%0d cyc=%0d len=%0d",
                 g.kind, g.val, g.cyc, g.len, e.kind, e.val, e.cyc, e.len);
      end
    end
  endtask

  // Monitor: turns pin activity into segment/pulse events, plus idle-quiet checks.
  always @(negedge clk) begin
    ev_t g;
    int  v;
    if (mon_en) begin
      v = int'({bus.M2, bus.M1});
      if (bus.busy) begin
        if (prev_busy == 0 || v != cur_val) begin
          if (prev_busy != 0) begin
            g = '{kind: 0, val: cur_val, cyc: seg_start, len: cyc - seg_start};
            check_ev(g);
          end
          cur_val   = v;
          seg_start = cyc;
        end
      end else if (prev_busy != 0) begin
        g = '{kind: 0, val: cur_val, cyc: seg_start, len: cyc - seg_start};
        check_ev(g);
      end
      prev_busy = int'(bus.busy);
      if (bus.done) begin
        g = '{kind: 1, val: 0, cyc: cyc, len: 0};
        check_ev(g);
      end
      if (bus.aborted) begin
        g = '{kind: 2, val: 0, cyc: cyc, len: 0};
        check_ev(g);
      end
      n_cmp++;
      if ((!bus.busy && v != 0) || (bus.busy && (bus.done || bus.aborted)) || (bus.done && bus.aborted)) begin
        n_bad++;
        $display("FAIL quiet: cyc=%0d busy=%0d M2M1=%0d done=%0d aborted=%0d, required motors off and no pulse while busy",
                 cyc, bus.busy, v, bus.done, bus.aborted);
      end
    end
  end

  function automatic logic [6:0] mk(input int pad, input int dur, input int val);
    return {1'(pad), 4'(dur), 2'(val)};
  endfunction

  function automatic logic [PW-1:0] rand_pd();
    logic [PW-1:0] pd;
    for (int i = 0; i < ENTRIES; i++) pd[7*i +: 7] = 7'($urandom);
    return pd;
  endfunction

  function automatic int path_len(input logic [PW-1:0] pd, input int ec);
    int cnt = (ec > ENTRIES) ? ENTRIES : ec;
    int t = 0;
    for (int i = 0; i < cnt; i++) t += (int'(pd[7*i+2 +: 4]) + 1) * TICK;
    return t;
  endfunction

  // Reference model: expand the path into per-cycle motor values oldest-first,
  // truncate at a stop, then run-length encode into expected events.
  task automatic expect_replay(input logic [PW-1:0] pd, input int ec, input int k,
                               input int stop_kind, input int stop_at, output int total);
    int  cnt = (ec > ENTRIES) ? ENTRIES : ec;
    int  vals[$];
    int  n;
    int  i;
    int  j;
    ev_t e;
    for (int s = cnt - 1; s >= 0; s--) begin
      int d = int'(pd[7*s+2 +: 4]);
      int v = int'(pd[7*s +: 2]);
      repeat ((d + 1) * TICK) vals.push_back(v);
    end
    total = vals.size();
    n = (stop_kind == 0) ? total : stop_at - k + 1;
    i = 0;
    while (i < n) begin
      j = i;
      while (j < n && vals[j] == vals[i]) j++;
      e = '{kind: 0, val: vals[i], cyc: k + i, len: j - i};
      expq.push_back(e);
      i = j;
    end
    if (stop_kind == 0) begin
      e = '{kind: 1, val: 0, cyc: k + total, len: 0};
      expq.push_back(e);
    end else if (stop_kind == 1) begin
      e = '{kind: 2, val: 0, cyc: stop_at + 1, len: 0};
      expq.push_back(e);
    end
  endtask

  task automatic drive_noise();
    bus.start       = 1'($urandom_range(0, 1));
    bus.path_data   = rand_pd();
    bus.entry_count = 4'($urandom);
  endtask

  // stop_kind: 0 = run to completion, 1 = abort, 2 = reset; stop_off counts from the accept cycle.
  task automatic run_replay(input logic [PW-1:0] pd, input int ec, input int stop_kind,
                            input int stop_off, input bit noise);
    int k;
    int total;
    int stop_at;
    bus.path_data   = pd;
    bus.entry_count = 4'(ec);
    bus.start       = 1'b1;
    step();
    bus.start = 1'b0;
    k = cyc;
    stop_at = k + stop_off;
    expect_replay(pd, ec, k, stop_kind, stop_at, total);
    if (stop_kind != 0) begin
      while (cyc < stop_at) begin
        if (noise) drive_noise();
        step();
      end
      bus.start = 1'b0;
      if (stop_kind == 1) bus.abort = 1'b1;
      else rst = 1'b1;
      step();
      bus.abort = 1'b0;
      rst       = 1'b0;
    end else begin
      while (cyc < k + total + 1) begin
        if (noise && cyc <= k + total) drive_noise();
        else bus.start = 1'b0;
        step();
      end
      bus.start = 1'b0;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] pd;
    int k;
    int t1;
    int t2;
    int ec;
    int kind;
    int off;

    rst             = 1'b1;
    bus.start       = 1'b1;
    bus.abort       = 1'b0;
    bus.path_data   = rand_pd();
    bus.entry_count = 4'd3;
    repeat (3) step();
    chk("reset M1", int'(bus.M1), 0);
    chk("reset M2", int'(bus.M2), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset aborted", int'(bus.aborted), 0);
    bus.start = 1'b0;
    rst       = 1'b0;
    step();
    mon_en = 1'b1;

    // Basic two-slot replay, pad bit set on slot 0 to show it is ignored.
    pd = rand_pd();
    pd[13:7] = mk(0, 1, 1);
    pd[6:0]  = mk(1, 0, 2);
    run_replay(pd, 2, 0, 0, 1'b0);
    step();

    run_replay(rand_pd(), 0, 0, 0, 1'b0);

    pd = rand_pd();
    pd[6:0] = mk(0, 15, 3);
    run_replay(pd, 1, 1, 3, 1'b0);
    // Accepted straight after the aborted pulse.
    pd = rand_pd();
    pd[13:7] = mk(0, 1, 1);
    pd[6:0]  = mk(0, 0, 2);
    run_replay(pd, 2, 1, 7, 1'b0);

    pd = rand_pd();
    pd[13:7] = mk(0, 1, 1);
    pd[6:0]  = mk(0, 0, 2);
    run_replay(pd, 2, 0, 0, 1'b1);

    pd = rand_pd();
    for (int i = 0; i < ENTRIES; i++) pd[7*i+2 +: 4] = 4'd15;
    run_replay(pd, 15, 0, 0, 1'b0);

    pd = rand_pd();
    pd[6:0] = mk(0, 3, 1);
    pd[13:7] = mk(0, 2, 2);
    run_replay(pd, 2, 2, 5, 1'b0);

    bus.path_data   = rand_pd();
    bus.entry_count = 4'd2;
    bus.start       = 1'b1;
    bus.abort       = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (3) step();

    // Start held high: second replay begins on the first idle cycle after done.
    pd = rand_pd();
    pd[13:7] = mk(0, 0, 3);
    pd[6:0]  = mk(0, 1, 1);
    bus.path_data   = pd;
    bus.entry_count = 4'd2;
    bus.start       = 1'b1;
    step();
    k = cyc;
    expect_replay(pd, 2, k, 0, 0, t1);
    expect_replay(pd, 2, k + t1 + 2, 0, 0, t2);
    while (cyc < k + t1 + 2) step();
    bus.start = 1'b0;
    while (cyc < k + t1 + 2 + t2 + 1) step();

    for (int r = 0; r < 30; r++) begin
      pd   = rand_pd();
      ec   = $urandom_range(0, 15);
      kind = (ec == 0) ? 0 : (($urandom_range(0, 5) < 2) ? 1 : (($urandom_range(0, 5) == 0) ? 2 : 0));
      off  = (kind == 0) ? 0 : $urandom_range(0, path_len(pd, ec) - 1);
      run_replay(pd, ec, kind, off, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (5) step();
    chk("leftover expected events", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/path_replayer.md
PATH_REPLAYER -- requirements
Module: path_replayer

Interface
REQ-001 Parameter TICK, default 7644: clock cycles per duration unit.
REQ-002 Parameter ENTRIES, default 15: slot capacity of path_data.
REQ-003 clk  input  1  system clock; single clock domain, all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  replay request, sampled only in IDLE.
REQ-006 abort  input  1  stop replay immediately.
REQ-007 path_data  input  7*ENTRIES  packed slots; slot i = bits [7i+6:7i] = {pad, dur[3:0], M2, M1}; slot 0 newest.
REQ-008 entry_count  input  4  number of valid slots, counted from slot 0.
REQ-009 M1  output  1  motor 1 drive, registered.
REQ-010 M2  output  1  motor 2 drive, registered.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  one-cycle pulse on normal completion.
REQ-013 aborted  output  1  one-cycle pulse on abort completion.

Function
REQ-014 States SHALL be IDLE, RUN and FINISH; encoding is free.
REQ-015 The block SHALL latch path_data and entry_count into an internal snapshot on the edge that accepts start; later input changes have no effect on the replay.
REQ-016 Entry_count values above ENTRIES SHALL clamp to ENTRIES.
REQ-017 IDLE to RUN: start=1, abort=0, clamped count>0; on that edge index=count-1, tick counter=0, unit counter=0, {M2,M1}=slot[count-1] bits [1:0], busy=1.
REQ-018 IDLE to FINISH: start=1, abort=0, count=0; M1=M2=0, no RUN cycles.
REQ-019 Replay order SHALL be oldest first: slot count-1 down to slot 0.
REQ-020 Each slot's {M2,M1} SHALL be held exactly (dur+1)*TICK cycles; dur=0 gives TICK cycles, dur=15 gives 16*TICK.
REQ-021 Tick counter SHALL count 0..TICK-1; at wrap the unit counter increments; at unit counter==dur with tick wrap the slot ends.
REQ-022 Slot end with index>0: index decrements, {M2,M1} loads the next slot on the same edge, both counters clear; there is no gap cycle between slots.
REQ-023 Slot end with index==0: M1=M2=0, busy=0, next state FINISH.
REQ-024 FINISH SHALL assert done for exactly one cycle, then return to IDLE.
REQ-025 Abort=1 in RUN: on the next edge M1=M2=0, busy=0, aborted=1 for one cycle, state IDLE, done never asserted.
REQ-026 Abort coinciding with a slot end SHALL win over the slot end.
REQ-027 Abort=1 in IDLE SHALL suppress start in the same cycle; no pulse results.
REQ-028 Start while busy or in FINISH SHALL be ignored; it is not queued.
REQ-029 Start held high continuously SHALL re-trigger a replay on the first IDLE cycle after done.
REQ-030 The pad bit SHALL be ignored.
REQ-031 Counter widths SHALL hold TICK-1 without overflow; the unit counter is 4 bits.

Reset
REQ-032 With rst=1 at an edge: state=IDLE, M1=M2=0, busy=0, done=0, aborted=0, all counters and index cleared, snapshot cleared.
REQ-033 Rst SHALL take priority over start and abort.
REQ-034 Rst asserted mid-RUN SHALL stop the motors on that edge with no done or aborted pulse.

Verification (TICK=4)
REQ-035 Basic replay: count=2, slot1={dur=1,M2M1=01}, slot0={dur=0,M2M1=10}, start pulse.
  - M2M1=01 for 8 cycles, then 10 for 4 cycles, then 00.
  - done pulses 1 cycle after the last slot ends; busy high for exactly 12 cycles.
REQ-036 Empty path: count=0, start.
  - busy never rises; done pulses 1 cycle later; M1=M2=0 throughout.
REQ-037 Abort mid-RUN: abort asserted 3 cycles into a dur=15 slot.
  - Next edge: M1=M2=0, aborted=1 for one cycle, done=0; a new start is accepted the cycle after.
REQ-038 Input isolation: change path_data and pulse start while busy.
  - The replay uses the original snapshot; the extra start produces no second replay.
REQ-039 Clamp and max duration: count=15 with every slot dur=15.
  - busy high 15*16*4=960 cycles, then done.
REQ-040 Reset mid-RUN: rst for 1 cycle at cycle 5 of a replay.
  - All outputs 0 on the next cycle; no done or aborted pulse.
